// File: rtl/alu_issue_stage.sv
// Operand/result stage around the combinational ALU: holds Y, captures opcode/A/B on issue, latches Zin after per-opcode settle.
// Latency 1+wait edges from issue to Z capture (wait = MUL_WAIT/DIV_WAIT/0); op_ready low during EXEC, op_valid ignored there.
module alu_issue_stage #(
    parameter int unsigned MUL_WAIT = 2,
    parameter int unsigned DIV_WAIT = 4
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] bus_in,
    input  logic        Yin,
    input  logic        op_valid,
    input  logic [4:0]  opcode_in,
    output logic        op_ready,
    output logic [4:0]  opcode,
    output logic [31:0] A,
    output logic [31:0] B,
    input  logic [63:0] Zin,
    output logic [31:0] ZHI,
    output logic [31:0] ZLO,
    output logic        z_valid,
    output logic        illegal
);

    localparam logic [4:0] OP_ADD  = 5'b01100;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_DIV  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00100;

    localparam logic [3:0] MUL_CNT = 4'(MUL_WAIT);
    localparam logic [3:0] DIV_CNT = 4'(DIV_WAIT);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] y_reg;
    logic [3:0]  cnt;
    logic        op_legal;
    logic [3:0]  op_wait;

    always_comb begin
        op_legal = 1'b0;
        case (opcode_in)
            OP_ADD, OP_AND, OP_OR, OP_NOT, OP_NEG, OP_MUL, OP_ROR,
            OP_ROL, OP_SHL, OP_SHR, OP_SHRA, OP_DIV, OP_SUB: op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    end

    always_comb begin
        op_wait = 4'd0;
        if (opcode_in == OP_MUL)
            op_wait = MUL_CNT;
        else if (opcode_in == OP_DIV)
            op_wait = DIV_CNT;
    end

    // state is forced to IDLE asynchronously, so the OR with clear only covers the reset window itself
    assign op_ready = clear || (state == IDLE);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state   <= IDLE;
            y_reg   <= 32'd0;
            opcode  <= 5'b00000;
            A       <= 32'd0;
            B       <= 32'd0;
            cnt     <= 4'd0;
            ZHI     <= 32'd0;
            ZLO     <= 32'd0;
            z_valid <= 1'b0;
            illegal <= 1'b0;
        end else begin
            z_valid <= 1'b0;
            illegal <= 1'b0;
            if (Yin)
                y_reg <= bus_in;
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        if (op_legal) begin
                            // A takes Y before any same-edge Yin load
                            opcode <= opcode_in;
                            A      <= y_reg;
                            B      <= bus_in;
                            cnt    <= op_wait;
                            state  <= EXEC;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        ZHI     <= Zin[63:32];
                        ZLO     <= Zin[31:0];
                        z_valid <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: reference ALU drives Zin, an edge-count model predicts outputs every cycle.
module tb_alu_issue_stage;

    localparam int MW = 2;
    localparam int DW = 4;

    localparam logic [4:0] ADD = 5'b01100, AND_ = 5'b01010, OR_ = 5'b01011;
    localparam logic [4:0] MUL = 5'b01111, DIV = 5'b00001, SUB = 5'b00100;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] bus_in;
    logic        Yin;
    logic        op_valid;
    logic [4:0]  opcode_in;
    logic        op_ready;
    logic [4:0]  opcode;
    logic [31:0] a_o, b_o;
    logic [63:0] zin;
    logic [31:0] zhi, zlo;
    logic        z_valid, illegal;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    alu_issue_stage #(.MUL_WAIT(MW), .DIV_WAIT(DW)) dut (
        .clock(clock), .clear(clear), .bus_in(bus_in), .Yin(Yin),
        .op_valid(op_valid), .opcode_in(opcode_in), .op_ready(op_ready),
        .opcode(opcode), .A(a_o), .B(b_o), .Zin(zin),
        .ZHI(zhi), .ZLO(zlo), .z_valid(z_valid), .illegal(illegal)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic [63:0] p;
        r = 32'd0;
        case (op)
            5'b01100: r = a + b;
            5'b00100: r = a - b;
            5'b01010: r = a & b;
            5'b01011: r = a | b;
            5'b10010: r = ~a;
            5'b10001: r = -a;
            5'b01000: r = (a >> b[4:0]) | (a << (6'd32 - {1'b0, b[4:0]}));
            5'b01001: r = (a << b[4:0]) | (a >> (6'd32 - {1'b0, b[4:0]}));
            5'b00111: r = a << b[4:0];
            5'b00101: r = a >> b[4:0];
            5'b00110: r = $unsigned($signed(a) >>> b[4:0]);
            5'b01111: begin
                p = $unsigned($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
                return p;
            end
            5'b00001: begin
                if (b == 32'd0) return 64'd0;
                return {$unsigned($signed(a) % $signed(b)), $unsigned($signed(a) / $signed(b))};
            end
            default: r = 32'd0;
        endcase
        return {32'd0, r};
    endfunction

    // environment ALU: purely combinational on what the stage presents
    assign zin = alu_ref(opcode, a_o, b_o);

    function automatic bit is_legal(input logic [4:0] op);
        return op inside {5'b01100, 5'b01010, 5'b01011, 5'b10010, 5'b10001, 5'b01111, 5'b01000,
                          5'b01001, 5'b00111, 5'b00101, 5'b00110, 5'b00001, 5'b00100};
    endfunction

    function automatic int wait_of(input logic [4:0] op);
        if (op == 5'b01111) return MW;
        if (op == 5'b00001) return DW;
        return 0;
    endfunction

    // model: results fall due at an absolute edge number computed at issue time
    int          edge_n = 0;
    int          m_due = 0;
    bit          m_busy = 0;
    logic [31:0] m_y = 0, m_a = 0, m_b = 0, m_zhi = 0, m_zlo = 0;
    logic [4:0]  m_op = 0;
    logic [63:0] m_res = 0;
    logic        m_zv = 0, m_ill = 0;

    always @(posedge clock or posedge clear) begin
        if (clear) begin
            m_y = 0; m_a = 0; m_b = 0; m_op = 0; m_zhi = 0; m_zlo = 0;
            m_zv = 0; m_ill = 0; m_busy = 0;
        end else begin
            edge_n++;
            m_zv = 0;
            m_ill = 0;
            if (!m_busy && op_valid) begin
                if (is_legal(opcode_in)) begin
                    m_op = opcode_in;
                    m_a = m_y;
                    m_b = bus_in;
                    m_res = alu_ref(opcode_in, m_y, bus_in);
                    m_due = edge_n + 1 + wait_of(opcode_in);
                    m_busy = 1;
                end else begin
                    m_ill = 1;
                end
            end else if (m_busy && edge_n == m_due) begin
                m_zhi = m_res[63:32];
                m_zlo = m_res[31:0];
                m_zv = 1;
                m_busy = 0;
            end
            if (Yin) m_y = bus_in;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("op_ready", 64'(op_ready), 64'(!m_busy));
            chk("opcode", 64'(opcode), 64'(m_op));
            chk("A", 64'(a_o), 64'(m_a));
            chk("B", 64'(b_o), 64'(m_b));
            chk("ZHI", 64'(zhi), 64'(m_zhi));
            chk("ZLO", 64'(zlo), 64'(m_zlo));
            chk("z_valid", 64'(z_valid), 64'(m_zv));
            chk("illegal", 64'(illegal), 64'(m_ill));
            chk("zv_ill_excl", 64'(z_valid & illegal), 64'd0);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_y(input logic [31:0] v);
        Yin = 1'b1;
        bus_in = v;
        step();
        Yin = 1'b0;
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] v);
        op_valid = 1'b1;
        opcode_in = op;
        bus_in = v;
        step();
        op_valid = 1'b0;
    endtask

    initial begin
        clear = 1'b1; Yin = 1'b0; op_valid = 1'b0; opcode_in = 5'd0; bus_in = 32'd0;
        repeat (3) @(posedge clock);
        #1 clear = 1'b0;
        chk_en = 1'b1;
        chk("rst_ready", 64'(op_ready), 64'd1);
        chk("rst_zlo", 64'(zlo), 64'd0);
        chk("rst_opcode", 64'(opcode), 64'd0);

        // ADD 5+7
        load_y(32'd5);
        issue(ADD, 32'd7);
        chk("add_busy", 64'(op_ready), 64'd0);
        chk("add_novalid", 64'(z_valid), 64'd0);
        step();
        chk("add_zv", 64'(z_valid), 64'd1);
        chk("add_zlo", 64'(zlo), 64'd12);
        chk("add_zhi", 64'(zhi), 64'd0);
        chk("add_ready", 64'(op_ready), 64'd1);
        step();
        chk("add_zv_once", 64'(z_valid), 64'd0);

        // MUL 0x10000 * 0x10000
        load_y(32'h0001_0000);
        issue(MUL, 32'h0001_0000);
        step();
        step();
        chk("mul_hold_zlo", 64'(zlo), 64'd12);
        chk("mul_hold_zv", 64'(z_valid), 64'd0);
        step();
        chk("mul_zhi", 64'(zhi), 64'd1);
        chk("mul_zlo", 64'(zlo), 64'd0);
        chk("mul_zv", 64'(z_valid), 64'd1);

        // DIV 17/5 with an ignored op_valid during EXEC
        load_y(32'd17);
        issue(DIV, 32'd5);
        op_valid = 1'b1; opcode_in = ADD; bus_in = 32'd1;
        step();
        op_valid = 1'b0;
        chk("div_ignore_opc", 64'(opcode), 64'(DIV));
        repeat (3) step();
        chk("div_early_zv", 64'(z_valid), 64'd0);
        step();
        chk("div_zlo", 64'(zlo), 64'd3);
        chk("div_zhi", 64'(zhi), 64'd2);
        chk("div_zv", 64'(z_valid), 64'd1);

        // illegal after ADD result 12
        load_y(32'd5);
        issue(ADD, 32'd7);
        step();
        step();
        issue(5'b11111, 32'd99);
        chk("ill_pulse", 64'(illegal), 64'd1);
        chk("ill_ready", 64'(op_ready), 64'd1);
        chk("ill_opcode", 64'(opcode), 64'(ADD));
        chk("ill_zlo", 64'(zlo), 64'd12);
        chk("ill_a", 64'(a_o), 64'd5);
        step();
        chk("ill_once", 64'(illegal), 64'd0);
        chk("ill_nozv", 64'(z_valid), 64'd0);

        // clear two cycles into a DIV
        load_y(32'd20);
        issue(DIV, 32'd3);
        step();
        #2 clear = 1'b1;
        #1;
        chk("clr_zlo", 64'(zlo), 64'd0);
        chk("clr_zhi", 64'(zhi), 64'd0);
        chk("clr_ready", 64'(op_ready), 64'd1);
        #2 clear = 1'b0;
        repeat (6) begin
            step();
            chk("clr_nozv", 64'(z_valid), 64'd0);
        end
        load_y(32'd9);
        issue(SUB, 32'd4);
        step();
        chk("sub_zlo", 64'(zlo), 64'd5);

        // back-to-back OR then AND, Y loads around the AND
        load_y(32'h0000_F0F0);
        issue(OR_, 32'h0000_0F00);
        step();
        chk("or_zlo", 64'(zlo), 64'h0000_FFF0);
        Yin = 1'b1;
        issue(AND_, 32'h0000_00FF);
        Yin = 1'b0;
        chk("and_a", 64'(a_o), 64'h0000_F0F0);
        chk("and_b", 64'(b_o), 64'h0000_00FF);
        load_y(32'h0000_1234);
        chk("and_zlo", 64'(zlo), 64'h0000_00F0);
        chk("and_zv", 64'(z_valid), 64'd1);
        chk("and_a_hold", 64'(a_o), 64'h0000_F0F0);
        issue(ADD, 32'd1);
        step();
        chk("y_iso_zlo", 64'(zlo), 64'h0000_1235);
        step();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
